// File: rtl/gain_mac_pkg.sv
// Shared widths, saturation bounds and pipeline entry type for gain_mac_arbiter.
// Values here describe the default configuration (12-bit samples, 8-bit Q1.6 gain, 4 requesters).
package gain_mac_pkg;

  localparam int unsigned DEF_NUM_REQ   = 4;
  localparam int unsigned DEF_SAMPLE_W  = 12;
  localparam int unsigned DEF_GAIN_W    = 8;
  localparam int unsigned DEF_GAIN_FRAC = 6;

  localparam int unsigned PROD_W = DEF_SAMPLE_W + DEF_GAIN_W;

  // Requester id width; a single requester still carries a 1-bit id.
  function automatic int unsigned id_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DEF_ID_W = id_w(DEF_NUM_REQ);

  localparam logic signed [DEF_SAMPLE_W-1:0] SAT_MAX = {1'b0, {(DEF_SAMPLE_W-1){1'b1}}};
  localparam logic signed [DEF_SAMPLE_W-1:0] SAT_MIN = {1'b1, {(DEF_SAMPLE_W-1){1'b0}}};

  typedef struct packed {
    logic                valid;
    logic [DEF_ID_W-1:0] id;
    logic [PROD_W-1:0]   data;
  } pipe_entry_t;

endpackage

// File: rtl/sat_narrow.sv
// Signed saturating narrow from IN_W to OUT_W bits; sat flags a clipped value.
module sat_narrow #(
  parameter int unsigned IN_W  = 20,
  parameter int unsigned OUT_W = 12
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    sat
);

  // In range exactly when all bits above the output MSB match the sign bit.
  always_comb begin
    sat  = 1'b0;
    dout = din[OUT_W-1:0];
    if (din[IN_W-1:OUT_W-1] != {(IN_W-OUT_W+1){din[IN_W-1]}}) begin
      sat  = 1'b1;
      dout = din[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/signed_expand.sv
// Sign-extends a signed vector by expansion_size bits.
module signed_expand #(
  parameter int unsigned WIDTH          = 12,
  parameter int unsigned EXPANSION_SIZE = 8
) (
  input  logic [WIDTH-1:0]                din,
  output logic [WIDTH+EXPANSION_SIZE-1:0] dout
);

  // Replicate the sign bit into the new upper bits.
  assign dout = {{EXPANSION_SIZE{din[WIDTH-1]}}, din};

endmodule

// File: rtl/gain_mac_arbiter.sv
// Round-robin shared signed gain multiplier for the effect chain.
// Three-stage pipeline: accept/extend, multiply, shift+saturate into the output registers.
// Build option GAIN_MAC_ROUND_EN: add half an LSB before the shift (round half up)
// instead of the default floor shift.
module gain_mac_arbiter
  import gain_mac_pkg::*;
#(
  parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
  parameter int unsigned SAMPLE_W  = DEF_SAMPLE_W,
  parameter int unsigned GAIN_W    = DEF_GAIN_W,
  parameter int unsigned GAIN_FRAC = DEF_GAIN_FRAC
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*SAMPLE_W-1:0]  req_sample,
  input  logic [NUM_REQ*GAIN_W-1:0]    req_gain,
  output logic [NUM_REQ-1:0]           resp_valid,
  output logic [SAMPLE_W-1:0]          resp_data,
  output logic                         resp_sat
);

  localparam int unsigned EXT_W = SAMPLE_W + GAIN_W;
  localparam int unsigned ID_W  = id_w(NUM_REQ);

  logic [ID_W-1:0]           ptr;
  logic [ID_W-1:0]           gid;
  logic [NUM_REQ-1:0]        grant;
  logic                      found;
  logic                      accept;
  logic [SAMPLE_W-1:0]       sel_sample;
  logic [GAIN_W-1:0]         sel_gain;
  logic [EXT_W-1:0]          ext_sample;

  logic                      s0_valid;
  logic [ID_W-1:0]           s0_id;
  logic signed [EXT_W-1:0]   s0_sample;
  logic signed [GAIN_W-1:0]  s0_gain;

  logic                      s1_valid;
  logic [ID_W-1:0]           s1_id;
  logic signed [EXT_W-1:0]   s1_prod;

  logic [SAMPLE_W-1:0]       nar_data;
  logic                      nar_sat;

  // Round-robin search from ptr; first valid requester wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    gid   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      int unsigned idx;
      idx = 32'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[ID_W'(idx)]) begin
        found             = 1'b1;
        gid               = ID_W'(idx);
        grant[ID_W'(idx)] = 1'b1;
      end
    end
  end

  assign req_ready  = rst ? '0 : grant;
  assign accept     = found && !rst;
  assign sel_sample = req_sample[32'(gid)*SAMPLE_W +: SAMPLE_W];
  assign sel_gain   = req_gain[32'(gid)*GAIN_W +: GAIN_W];

  signed_expand #(
    .WIDTH          (SAMPLE_W),
    .EXPANSION_SIZE (GAIN_W)
  ) u_expand (
    .din  (sel_sample),
    .dout (ext_sample)
  );

  // Pointer moves past the granted requester; holds when nobody asks.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (gid == ID_W'(NUM_REQ - 1)) ? '0 : gid + ID_W'(1);
    end
  end

  // S0: capture the accepted operands and owner id.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid <= 1'b0;
    end else begin
      s0_valid <= accept;
    end
    s0_id     <= gid;
    s0_sample <= ext_sample;
    s0_gain   <= sel_gain;
  end

  // S1: full-width signed product; the extended width cannot overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= s0_valid;
    end
    s1_id   <= s0_id;
    s1_prod <= s0_sample * EXT_W'(s0_gain);
  end

`ifdef GAIN_MAC_ROUND_EN
  localparam int unsigned NARROW_W = EXT_W + 1;
  logic signed [NARROW_W-1:0] rounded;
  logic signed [NARROW_W-1:0] shifted;
  assign rounded = NARROW_W'(s1_prod) + NARROW_W'(2 ** (GAIN_FRAC - 1));
  assign shifted = rounded >>> GAIN_FRAC;
`else
  localparam int unsigned NARROW_W = EXT_W;
  logic signed [NARROW_W-1:0] shifted;
  assign shifted = s1_prod >>> GAIN_FRAC;
`endif

  sat_narrow #(
    .IN_W  (NARROW_W),
    .OUT_W (SAMPLE_W)
  ) u_sat (
    .din  (shifted),
    .dout (nar_data),
    .sat  (nar_sat)
  );

  // S2: registered one-hot response to the owning requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= '0;
      resp_data  <= '0;
      resp_sat   <= 1'b0;
    end else begin
      resp_valid <= s1_valid ? (NUM_REQ'(1) << s1_id) : '0;
      if (s1_valid) begin
        resp_data <= nar_data;
        resp_sat  <= nar_sat;
      end
    end
  end

endmodule

// File: tb/tb_gain_mac_arbiter.sv
// Scoreboard bench for gain_mac_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares each resp_valid pulse.
module tb_gain_mac_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [47:0] req_sample;
  logic [31:0] req_gain;
  logic [3:0]  resp_valid;
  logic [11:0] resp_data;
  logic        resp_sat;

  gain_mac_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_sample (req_sample),
    .req_gain   (req_gain),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_sat   (resp_sat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  id;
    logic [11:0] data;
    logic        sat;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  bit   mon_en = 1'b0;

`ifdef GAIN_MAC_ROUND_EN
  localparam int NEG_HALF = 0;
`else
  localparam int NEG_HALF = -1;
`endif

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %0h want %0h", name, cyc, got, want);
    end
  endtask

  // Drive one cycle of requests (all lanes carry the same operands), check the grant,
  // and queue the expected response for the granted requester.
  task automatic step(input logic [3:0] v, input logic [3:0] exp_rdy, input int samp,
                      input int gain, input int exp_d, input logic exp_s, input bit track);
    exp_t e;
    req_valid  = v;
    req_sample = {4{12'(samp)}};
    req_gain   = {4{8'(gain)}};
    #1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (track && exp_rdy != 4'b0000) begin
      e.id   = exp_rdy;
      e.data = 12'(exp_d);
      e.sat  = exp_s;
      e.cyc  = cyc + 3;
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  // Monitor: every response pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && resp_valid !== 4'b0000) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL resp_unexpected cyc=%0d: got v=%b d=%0d", cyc, resp_valid, $signed(resp_data));
        end else begin
          e = q.pop_front();
          if (resp_valid !== e.id || resp_data !== e.data || resp_sat !== e.sat || cyc != e.cyc) begin
            n_bad++;
            $display("FAIL resp cyc=%0d: got v=%b d=%0d s=%b, want v=%b d=%0d s=%b at cyc=%0d",
                     cyc, resp_valid, $signed(resp_data), resp_sat,
                     e.id, $signed(e.data), e.sat, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    rst        = 1'b1;
    req_valid  = 4'b1111;
    req_sample = '0;
    req_gain   = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_data", 32'(resp_data), 32'h0);
    chk("rst_resp_sat", 32'(resp_sat), 32'h0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Single requests walking the pointer 0..3 twice.
    step(4'b0001, 4'b0001,   100,   64,   100, 1'b0, 1'b1);
    step(4'b0010, 4'b0010,  2047,  127,  2047, 1'b1, 1'b1);
    step(4'b0100, 4'b0100, -2048, -128,  2047, 1'b1, 1'b1);
    step(4'b1000, 4'b1000,    -1,   32, NEG_HALF, 1'b0, 1'b1);
    step(4'b0001, 4'b0001,  1500,    0,     0, 1'b0, 1'b1);
    step(4'b0010, 4'b0010, -2048,  127, -2048, 1'b1, 1'b1);
    step(4'b0100, 4'b0100,  1000,   96,  1500, 1'b0, 1'b1);
    step(4'b1000, 4'b1000,  -600,   64,  -600, 1'b0, 1'b1);
    step(4'b0000, 4'b0000,     0,    0,     0, 1'b0, 1'b1);

    // Fairness: everyone asks for 12 cycles.
    for (int k = 0; k < 12; k++) begin
      logic [3:0] g;
      g = 4'(1 << (k % 4));
      step(4'b1111, g, k*100 - 500, 64, k*100 - 500, 1'b0, 1'b1);
    end

    // Sparse: only 2 and 3; an idle cycle must hold the pointer.
    step(4'b1100, 4'b0100,   300,  -32,  -150, 1'b0, 1'b1);
    step(4'b1100, 4'b1000,  2000,   48,  1500, 1'b0, 1'b1);
    step(4'b1100, 4'b0100,    -7,  -64,     7, 1'b0, 1'b1);
    step(4'b0000, 4'b0000,     0,    0,     0, 1'b0, 1'b1);
    step(4'b1100, 4'b1000,    10,   64,    10, 1'b0, 1'b1);
    step(4'b0000, 4'b0000,     0,    0,     0, 1'b0, 1'b1);

    // Reset mid-flight: two accepts are dropped, pointer returns to 0.
    step(4'b0001, 4'b0001,     5,   64,     5, 1'b0, 1'b0);
    step(4'b0010, 4'b0010,     6,   64,     6, 1'b0, 1'b0);
    rst       = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("ready_in_rst", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step(4'b1001, 4'b0001,    50,   64,    50, 1'b0, 1'b1);
    step(4'b1000, 4'b1000,   -50,   64,   -50, 1'b0, 1'b1);
    step(4'b0000, 4'b0000,     0,    0,     0, 1'b0, 1'b1);

    repeat (6) @(negedge clk);
    chk("drain_outstanding", 32'(q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
